strobe_sequencer: RTL and testbench



---
 rtl/strobe_seq_pkg.sv | 19 +
 rtl/button_debouncer.sv | 50 +++++
 rtl/strobe_sequencer.sv | 127 ++++++++++++
 tb/tb_strobe_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/strobe_seq_pkg.sv
// Shared types and helpers for the front-panel strobe sequencer.
package strobe_seq_pkg;

  localparam int unsigned NUM_RATES = 4;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_MANUAL = 2'd1,
    ST_AUTO   = 2'd2
  } state_t;

  function automatic logic [NUM_RATES-1:0] onehot4(input logic [1:0] idx);
    logic [NUM_RATES-1:0] w_code;
    w_code      = '0;
    w_code[idx] = 1'b1;
    return w_code;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises one raw push-button, debounces it and emits a one-cycle pulse per accepted press.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 120_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_q;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
      r_pulse    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= btn_raw;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      // Rising edge of the accepted level only; releases never pulse.
      r_pulse    <= r_stable & ~r_stable_q;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level       = r_stable;
  assign press_pulse = r_pulse;

endmodule

// File: rtl/strobe_sequencer.sv
// Front-panel mode machine (OFF / MANUAL / AUTO) driving the one-hot strobe rate select.
module strobe_sequencer
  import strobe_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 120_000,
  parameter int unsigned DWELL_CYCLES    = 24_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_mode,
  output logic [3:0] select,
  output logic [1:0] rate_idx,
  output logic       auto_on
);

  localparam int unsigned      DW_W      = $clog2(DWELL_CYCLES);
  localparam logic [DW_W-1:0]  DWELL_MAX = DW_W'(DWELL_CYCLES - 1);

  logic       w_p_next;
  logic       w_p_prev;
  logic       w_p_mode;
  logic [2:0] w_levels_unused;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_next),
    .level       (w_levels_unused[0]),
    .press_pulse (w_p_next)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_prev),
    .level       (w_levels_unused[1]),
    .press_pulse (w_p_prev)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_mode),
    .level       (w_levels_unused[2]),
    .press_pulse (w_p_mode)
  );

  state_t            r_state;
  logic [1:0]        r_rate;
  logic [DW_W-1:0]   r_dwell;
  logic [3:0]        r_select;
  logic              r_auto;

  state_t            w_state_d;
  logic [1:0]        w_rate_d;
  logic [DW_W-1:0]   w_dwell_d;
  logic [3:0]        w_select_d;
  logic              w_auto_d;
  logic              w_step;
  logic [1:0]        w_rate_user;

  // Simultaneous next+prev cancel out and count as no user step at all.
  assign w_step      = w_p_next ^ w_p_prev;
  assign w_rate_user = w_p_next ? (r_rate + 2'd1) : (r_rate - 2'd1);

  always_comb begin
    w_state_d = r_state;
    w_rate_d  = r_rate;
    w_dwell_d = r_dwell;
    unique case (r_state)
      ST_OFF: begin
        if (w_p_mode) w_state_d = ST_MANUAL;
      end
      ST_MANUAL: begin
        if (w_p_mode) begin
          w_state_d = ST_AUTO;
          w_dwell_d = '0;
        end else if (w_step) begin
          w_rate_d = w_rate_user;
        end
      end
      ST_AUTO: begin
        if (w_p_mode) begin
          w_state_d = ST_OFF;
          w_dwell_d = '0;
        end else if (w_step) begin
          w_rate_d  = w_rate_user;
          w_dwell_d = '0;
        end else if (r_dwell == DWELL_MAX) begin
          w_rate_d  = r_rate + 2'd1;
          w_dwell_d = '0;
        end else begin
          w_dwell_d = r_dwell + 1'b1;
        end
      end
      default: begin
        w_state_d = ST_OFF;
        w_dwell_d = '0;
      end
    endcase
    w_select_d = (w_state_d == ST_OFF) ? 4'b0000 : onehot4(w_rate_d);
    w_auto_d   = (w_state_d == ST_AUTO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_OFF;
      r_rate   <= 2'd0;
      r_dwell  <= '0;
      r_select <= 4'b0000;
      r_auto   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_rate   <= w_rate_d;
      r_dwell  <= w_dwell_d;
      r_select <= w_select_d;
      r_auto   <= w_auto_d;
    end
  end

  assign select   = r_select;
  assign rate_idx = r_rate;
  assign auto_on  = r_auto;

endmodule

// File: tb/tb_strobe_sequencer.sv
// Self-checking bench: behavioural model compared every cycle, plus directed literal checks.
module tb_strobe_sequencer;

  localparam int unsigned D  = 4;
  localparam int unsigned DW = 16;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       btn_mode = 1'b0;
  logic [3:0] select;
  logic [1:0] rate_idx;
  logic       auto_on;

  int n_checks = 0;
  int n_fail   = 0;

  strobe_sequencer #(
    .DEBOUNCE_CYCLES (D),
    .DWELL_CYCLES    (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_next (btn_next),
    .btn_prev (btn_prev),
    .btn_mode (btn_mode),
    .select   (select),
    .rate_idx (rate_idx),
    .auto_on  (auto_on)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Button b (0 next, 1 prev, 2 mode): raw history of samples, newest in bit 0.
  // The level is accepted once the twice-delayed raw value has disagreed with the
  // accepted level for D consecutive samples; the FSM sees the press two edges later.
  logic [D+1:0] m_hist  [3];
  logic         m_stab  [3];
  logic         m_rose1 [3];
  logic         m_rose2 [3];
  int           m_mode  = 0;  // 0 off, 1 manual, 2 auto
  int           m_rate  = 0;
  int           m_dwell = 0;
  logic [2:0]   m_raw;
  logic [2:0]   m_p;
  logic [D-1:0] m_win;

  initial begin
    for (int b = 0; b < 3; b++) begin
      m_hist[b] = '0; m_stab[b] = 1'b0; m_rose1[b] = 1'b0; m_rose2[b] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 3; b++) begin
        m_hist[b] = '0; m_stab[b] = 1'b0; m_rose1[b] = 1'b0; m_rose2[b] = 1'b0;
      end
      m_mode = 0; m_rate = 0; m_dwell = 0;
    end else begin
      m_raw = {btn_mode, btn_prev, btn_next};
      for (int b = 0; b < 3; b++) m_p[b] = m_rose2[b];
      if (m_mode == 0) begin
        if (m_p[2]) m_mode = 1;
      end else if (m_p[2]) begin
        m_mode  = (m_mode == 1) ? 2 : 0;
        m_dwell = 0;
      end else if (m_p[0] != m_p[1]) begin
        m_rate = (m_rate + (m_p[0] ? 1 : 3)) % 4;
        if (m_mode == 2) m_dwell = 0;
      end else if (m_mode == 2) begin
        if (m_dwell == DW - 1) begin
          m_rate  = (m_rate + 1) % 4;
          m_dwell = 0;
        end else begin
          m_dwell++;
        end
      end
      for (int b = 0; b < 3; b++) begin
        m_rose2[b] = m_rose1[b];
        m_hist[b]  = {m_hist[b][D:0], m_raw[b]};
        m_win      = m_hist[b][D+1:2];
        if (m_win == {D{~m_stab[b]}}) begin
          m_rose1[b] = ~m_stab[b];
          m_stab[b]  = ~m_stab[b];
        end else begin
          m_rose1[b] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_sel;
    exp_sel = (m_mode == 0) ? 4'b0000 : (4'b0001 << m_rate);
    chk("model_select", select, exp_sel);
    chk("model_rate", {2'b00, rate_idx}, 4'(m_rate));
    chk("model_auto", {3'b000, auto_on}, {3'b000, m_mode == 2});
    chk("select_onehot", {3'b000, $countones(select) <= 1}, 4'd1);
  end

  // ---------------- stimulus ----------------
  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       btn_next = v;
      1:       btn_prev = v;
      default: btn_mode = v;
    endcase
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    repeat (D + 6) @(negedge clk);
    set_btn(which, 1'b0);
    repeat (D + 6) @(negedge clk);
  endtask

  int   hold [3];
  logic lvl  [3];

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_select", select, 4'b0000);
    chk("idle_rate", {2'b00, rate_idx}, 4'd0);
    chk("idle_auto", {3'b000, auto_on}, 4'd0);

    // Mode press latency: visible after edge D+4, not before.
    btn_mode = 1'b1;
    repeat (D + 3) @(negedge clk);
    chk("mode_latency_early", select, 4'b0000);
    @(negedge clk);
    chk("mode_latency", select, 4'b0001);
    btn_mode = 1'b0;
    repeat (D + 6) @(negedge clk);

    // Highs shorter than D samples never become a press.
    for (int i = 1; i < int'(D); i++) begin
      btn_next = 1'b1;
      repeat (i) @(negedge clk);
      btn_next = 1'b0;
      repeat (D + 6) @(negedge clk);
    end
    chk("glitch_rejected", select, 4'b0001);

    press(0); chk("next_1", select, 4'b0010);
    press(0); chk("next_2", select, 4'b0100);
    press(0); chk("next_3", select, 4'b1000);
    press(0); chk("next_wrap", select, 4'b0001);
    press(1); chk("prev_wrap", select, 4'b1000);
    press(1); chk("prev_to_2", select, 4'b0100);

    // AUTO entry at rate 2, dwell steps every DW cycles.
    btn_mode = 1'b1;
    repeat (D + 4) @(negedge clk);
    chk("auto_entry", select, 4'b0100);
    chk("auto_on_entry", {3'b000, auto_on}, 4'd1);
    btn_mode = 1'b0;
    repeat (DW - 1) @(negedge clk);
    chk("auto_hold", select, 4'b0100);
    @(negedge clk);
    chk("auto_step1", select, 4'b1000);
    repeat (DW) @(negedge clk);
    chk("auto_step2", select, 4'b0001);
    // User step lands when the dwell counter holds 10.
    repeat (3) @(negedge clk);
    btn_next = 1'b1;
    repeat (D + 3) @(negedge clk);
    chk("auto_user_early", select, 4'b0001);
    @(negedge clk);
    chk("auto_user_step", select, 4'b0010);
    btn_next = 1'b0;
    repeat (DW - 1) @(negedge clk);
    chk("auto_restart_hold", select, 4'b0010);
    @(negedge clk);
    chk("auto_restart_step", select, 4'b0100);

    // Mode and next together in AUTO: mode wins.
    btn_mode = 1'b1;
    btn_next = 1'b1;
    repeat (D + 4) @(negedge clk);
    chk("mode_wins_select", select, 4'b0000);
    chk("mode_wins_rate", {2'b00, rate_idx}, 4'd2);
    chk("mode_wins_auto", {3'b000, auto_on}, 4'd0);
    btn_mode = 1'b0;
    btn_next = 1'b0;
    repeat (D + 6) @(negedge clk);
    press(2);
    chk("resume_rate", select, 4'b0100);

    // Next and prev together in MANUAL: no step.
    btn_next = 1'b1;
    btn_prev = 1'b1;
    repeat (D + 6) @(negedge clk);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (D + 6) @(negedge clk);
    chk("both_steps_select", select, 4'b0100);

    // Asynchronous reset mid-AUTO, mode button held across release.
    btn_mode = 1'b1;
    repeat (D + 4) @(negedge clk);
    chk("auto_before_reset", {3'b000, auto_on}, 4'd1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_select", select, 4'b0000);
    chk("async_reset_rate", {2'b00, rate_idx}, 4'd0);
    chk("async_reset_auto", {3'b000, auto_on}, 4'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (D + 3) @(negedge clk);
    chk("held_reset_early", select, 4'b0000);
    @(negedge clk);
    chk("held_reset_press", select, 4'b0001);
    repeat (100) @(negedge clk);
    chk("held_no_repeat", select, 4'b0001);
    chk("held_no_repeat_auto", {3'b000, auto_on}, 4'd0);
    btn_mode = 1'b0;
    repeat (D + 6) @(negedge clk);

    // Random phase: mixed glitches, presses and overlaps.
    for (int b = 0; b < 3; b++) begin
      hold[b] = $urandom_range(1, 3 * D);
      lvl[b]  = 1'b0;
    end
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          lvl[b]  = ~lvl[b];
          hold[b] = lvl[b] ? $urandom_range(1, 3 * D) : $urandom_range(1, 8 * D);
        end else begin
          hold[b]--;
        end
      end
      btn_next = lvl[0];
      btn_prev = lvl[1];
      btn_mode = lvl[2];
      if ($urandom_range(0, 1499) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
